// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the memory model.
// The arbiter takes the slave side; pipeline/memory stimulus takes the master side.
interface mem_arbiter_if #(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned D_WIDTH = 32
);
  logic               i_req;
  logic [A_WIDTH-1:0] i_addr;
  logic [D_WIDTH-1:0] i_rdata;
  logic               i_ack;
  logic               d_req;
  logic               d_we;
  logic [A_WIDTH-1:0] d_addr;
  logic [D_WIDTH-1:0] d_wdata;
  logic [D_WIDTH-1:0] d_rdata;
  logic               d_ack;
  logic               mem_en;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               stall_f;
  logic               stall_m;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m
  );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: on a tie the port not served last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t owner
);

  // Pick the owner from the current requests and the previous winner.
  always_comb begin
    valid = i_req | d_req;
    owner = OWN_I;
    if (i_req && d_req) begin
      owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-ported unified memory shared by fetch (I) and memory (D) stages.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MEM_LAT) + 1;

  state_t             state, state_n;
  owner_t             owner_q, last_owner, gnt_owner;
  logic               gnt_valid;
  logic [A_WIDTH-1:0] addr_q;
  logic               we_q;
  logic [D_WIDTH-1:0] wdata_q;
  logic [CW-1:0]      cnt;
  logic [D_WIDTH-1:0] i_rdata_q, d_rdata_q;
  logic               mem_en, mem_we, i_ack, d_ack;

  arb_rr2 u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_owner (last_owner),
    .valid      (gnt_valid),
    .owner      (gnt_owner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_n = state;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    case (state)
      IDLE:  if (gnt_valid) state_n = ISSUE;
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        state_n = we_q ? RESP : WAIT;
      end
      WAIT:  if (cnt == '0) state_n = RESP;
      RESP:  begin
        i_ack   = (owner_q == OWN_I);
        d_ack   = (owner_q == OWN_D);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Transaction latch, latency counter, read-data capture and fairness history.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_I;
      last_owner <= OWN_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          owner_q <= gnt_owner;
          if (gnt_owner == OWN_D) begin
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
          end else begin
            // Fetches never write; wdata keeps its last value on the bus.
            addr_q <= bus.i_addr;
            we_q   <= 1'b0;
          end
        end
        ISSUE: if (!we_q) cnt <= CW'(MEM_LAT - 1);
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (owner_q == OWN_I) begin
            i_rdata_q <= bus.mem_rdata;
          end else begin
            d_rdata_q <= bus.mem_rdata;
          end
        end
        RESP: last_owner <= owner_q;
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = i_ack;
  assign bus.d_ack     = d_ack;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_f   = bus.i_req & ~i_ack;
  assign bus.stall_m   = bus.d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=2, one with MEM_LAT=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.A_WIDTH(32), .D_WIDTH(32)) b2 ();
  mem_arbiter_if #(.A_WIDTH(32), .D_WIDTH(32)) b3 ();

  mem_arbiter #(.A_WIDTH(32), .D_WIDTH(32), .MEM_LAT(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  mem_arbiter #(.A_WIDTH(32), .D_WIDTH(32), .MEM_LAT(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  // Memory model: read data appears exactly MEM_LAT cycles after the strobe, junk otherwise.
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  logic [31:0] p2 [2];
  logic [31:0] p3 [3];

  // Latency delay lines for the two memory models.
  always @(posedge clk) begin
    p2[0] <= (b2.mem_en && !b2.mem_we) ? memval(b2.mem_addr) : JUNK;
    p2[1] <= p2[0];
    p3[0] <= (b3.mem_en && !b3.mem_we) ? memval(b3.mem_addr) : JUNK;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign b2.mem_rdata = p2[1];
  assign b3.mem_rdata = p3[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ens;
    int acks;

    rst        = 1'b1;
    b2.i_req   = 1'b1;
    b2.i_addr  = 32'h104;
    b2.d_req   = 1'b1;
    b2.d_we    = 1'b0;
    b2.d_addr  = 32'h300;
    b2.d_wdata = 32'h0;
    b3.i_req   = 1'b0;
    b3.i_addr  = 32'h0;
    b3.d_req   = 1'b0;
    b3.d_we    = 1'b0;
    b3.d_addr  = 32'h0;
    b3.d_wdata = 32'h0;

    // Reset held two cycles with both requests high.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_i_ack",     b2.i_ack,     0);
      check("rst_d_ack",     b2.d_ack,     0);
      check("rst_mem_en",    b2.mem_en,    0);
      check("rst_mem_we",    b2.mem_we,    0);
      check("rst_mem_addr",  b2.mem_addr,  0);
      check("rst_mem_wdata", b2.mem_wdata, 0);
      check("rst_i_rdata",   b2.i_rdata,   0);
      check("rst_d_rdata",   b2.d_rdata,   0);
    end
    rst = 1'b0;

    // Continuous contention: D first, then I, D, I.
    for (int c = 1; c <= 19; c++) begin
      tick();
      check("cont_mem_en", b2.mem_en, (c == 1 || c == 6 || c == 11 || c == 16));
      check("cont_d_ack",  b2.d_ack,  (c == 4 || c == 14));
      check("cont_i_ack",  b2.i_ack,  (c == 9 || c == 19));
      if (c == 1 || c == 11) check("cont_addr_d", b2.mem_addr, 32'h300);
      if (c == 6 || c == 16) check("cont_addr_i", b2.mem_addr, 32'h104);
      if (c == 4 || c == 14) check("cont_d_rdata", b2.d_rdata, 32'hFFFFFCFF);
      if (c == 9 || c == 19) check("cont_i_rdata", b2.i_rdata, 32'hFFFFFEFB);
    end
    b2.i_req = 1'b0;
    b2.d_req = 1'b0;
    tick();
    tick();
    check("idle_mem_en",  b2.mem_en,  0);
    check("idle_stall_f", b2.stall_f, 0);

    // I load at 0x100.
    b2.i_addr = 32'h100;
    b2.i_req  = 1'b1;
    #1;
    check("iload_stall_f0", b2.stall_f, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("iload_mem_en",  b2.mem_en,  (k == 1));
      check("iload_i_ack",   b2.i_ack,   (k == 4));
      check("iload_stall_f", b2.stall_f, (k < 4));
      if (k == 1) begin
        check("iload_addr", b2.mem_addr, 32'h100);
        check("iload_we",   b2.mem_we,   0);
      end
      if (k == 4) check("iload_rdata", b2.i_rdata, 32'hDEADBEEF);
    end
    b2.i_req = 1'b0;
    tick();
    check("iload_ack_drop", b2.i_ack,   0);
    check("iload_hold",     b2.i_rdata, 32'hDEADBEEF);

    // D store.
    b2.d_we    = 1'b1;
    b2.d_addr  = 32'h200;
    b2.d_wdata = 32'h12345678;
    b2.d_req   = 1'b1;
    #1;
    check("st_stall_m0", b2.stall_m, 1);
    tick();
    check("st_mem_en", b2.mem_en,    1);
    check("st_mem_we", b2.mem_we,    1);
    check("st_addr",   b2.mem_addr,  32'h200);
    check("st_wdata",  b2.mem_wdata, 32'h12345678);
    check("st_no_ack", b2.d_ack,     0);
    tick();
    check("st_d_ack",   b2.d_ack,   1);
    check("st_en_low",  b2.mem_en,  0);
    check("st_rdata",   b2.d_rdata, 32'hFFFFFCFF);
    check("st_stall_m", b2.stall_m, 0);
    b2.d_req = 1'b0;
    tick();
    check("st_ack_drop",   b2.d_ack,     0);
    check("st_we_low",     b2.mem_we,    0);
    check("st_wdata_hold", b2.mem_wdata, 32'h12345678);
    check("st_addr_hold",  b2.mem_addr,  32'h200);

    // Reset while a D load waits for memory.
    b2.d_we   = 1'b0;
    b2.d_addr = 32'h300;
    b2.d_req  = 1'b1;
    tick();
    check("rw_issue", b2.mem_en, 1);
    tick();
    check("rw_wait_no_ack", b2.d_ack, 0);
    rst      = 1'b1;
    b2.d_req = 1'b0;
    tick();
    check("rw_rst_ack",   b2.d_ack,   0);
    check("rw_rst_rdata", b2.d_rdata, 0);
    check("rw_rst_en",    b2.mem_en,  0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rw_after_ack",   b2.d_ack,   0);
      check("rw_after_en",    b2.mem_en,  0);
      check("rw_after_rdata", b2.d_rdata, 0);
    end

    // Back-to-back D loads with MEM_LAT=3.
    ens  = 0;
    acks = 0;
    b3.d_we   = 1'b0;
    b3.d_addr = 32'h40;
    b3.d_req  = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (b3.mem_en) ens++;
      check("b2b_mem_en", b3.mem_en, (k == 1 || k == 7 || k == 13));
      check("b2b_d_ack",  b3.d_ack,  (k == 5 || k == 11 || k == 17));
      if (b3.d_ack) begin
        acks++;
        check("b2b_en_per_ack", ens, acks);
        check("b2b_rdata", b3.d_rdata, 32'hFFFFFFBF);
      end
    end
    b3.d_req = 1'b0;
    tick();
    check("b2b_total_acks", acks, 3);
    check("b2b_ack_drop",   b3.d_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
